irq_pending_ctrl: RTL and testbench

Machine-mode interrupt front end for the pipelined RV32I core with exception/interrupt support. Samples external interrupt lines, keeps per-line pending state (edge or level), arbitrates by fixed priority and presents one registered request and cause to the trap path. The request reaches the trap unit through the pipeline's one-cycle gating stage. A request/acknowledge handshake plus an `mret` notification prevents nested interrupts.

---
 rtl/irq_pending_ctrl_pkg.sv | 21 ++
 rtl/irq_prio_enc.sv | 23 ++
 rtl/irq_pending_ctrl.sv | 124 ++++++++++++
 tb/tb_irq_pending_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_pending_ctrl_pkg.sv
// Shared definitions for the machine-mode interrupt front end: FSM encodings,
// boolean constants and the cause-to-mcause mapping used by the trap unit.
package irq_pending_ctrl_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_TRAP = 2'd2
  } irq_state_e;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Platform interrupts sit above the 16 standard causes, interrupt bit set.
  localparam logic [31:0] IRQ_MCAUSE_BASE = 32'h8000_0010;

  function automatic logic [31:0] irq_mcause(input logic [4:0] cause);
    return IRQ_MCAUSE_BASE | {27'd0, cause};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: lowest set index wins.
module irq_prio_enc #(
  parameter int NUM_IRQ = 8,
  parameter int CAUSE_W = 3
) (
  input  logic [NUM_IRQ-1:0] req_i,
  output logic               valid_o,
  output logic [CAUSE_W-1:0] index_o
);

  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    // Scan downwards so the lowest asserted index is the last one assigned.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        index_o = CAUSE_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt sampling, per-line pending state and request/ack/mret FSM.
// Define IRQ_SYNC_EN to insert a synchroniser flop ahead of the sample register.
module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
#(
  parameter int                 NUM_IRQ   = 8,
  parameter int                 CAUSE_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = {NUM_IRQ{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               global_ie_i,
  input  logic               ack_i,
  input  logic               mret_i,
  output logic               req_o,
  output logic [CAUSE_W-1:0] cause_o,
  output logic [NUM_IRQ-1:0] pending_o
);

  irq_state_e         state_q;
  logic               req_q;
  logic [CAUSE_W-1:0] cause_q;

  logic [NUM_IRQ-1:0] s_d, s_q, s_prev_q;
  logic [NUM_IRQ-1:0] pend_d, pend_q;
  logic [NUM_IRQ-1:0] set_vec, clr_vec, elig;
  logic               win_valid;
  logic [CAUSE_W-1:0] win_idx;
  logic               cause_elig;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] meta_q;
  // The sample register doubles as the second synchroniser stage.
  always_comb s_d = meta_q;
`else
  always_comb s_d = irq_i;
`endif

  // Sample stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef IRQ_SYNC_EN
      meta_q   <= '0;
`endif
      s_q      <= '0;
      s_prev_q <= '0;
    end else begin
`ifdef IRQ_SYNC_EN
      meta_q   <= irq_i;
`endif
      s_q      <= s_d;
      s_prev_q <= s_q;
    end
  end

  // Pending stage
  always_comb begin
    clr_vec = '0;
    if (state_q == IRQ_REQ && ack_i) clr_vec[cause_q] = 1'b1;
    clr_vec = clr_vec & EDGE_MASK;
    set_vec = s_q & ~s_prev_q & EDGE_MASK;
    // A fresh edge in the ack cycle keeps the line pending.
    pend_d  = (EDGE_MASK & ((pend_q & ~clr_vec) | set_vec)) | (~EDGE_MASK & s_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign elig       = pend_q & irq_en_i & {NUM_IRQ{global_ie_i}};
  assign cause_elig = elig[cause_q];

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .CAUSE_W (CAUSE_W)
  ) u_prio_enc (
    .req_i   (elig),
    .valid_o (win_valid),
    .index_o (win_idx)
  );

  // Request FSM stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IRQ_IDLE;
      req_q   <= FALSE;
      cause_q <= '0;
    end else begin
      case (state_q)
        IRQ_IDLE: begin
          if (win_valid) begin
            state_q <= IRQ_REQ;
            req_q   <= TRUE;
            cause_q <= win_idx;
          end
        end
        IRQ_REQ: begin
          if (ack_i) begin
            state_q <= IRQ_TRAP;
            req_q   <= FALSE;
          end else if (!cause_elig) begin
            state_q <= IRQ_IDLE;
            req_q   <= FALSE;
          end
        end
        IRQ_TRAP: begin
          if (mret_i) state_q <= IRQ_IDLE;
        end
        default: begin
          state_q <= IRQ_IDLE;
          req_q   <= FALSE;
        end
      endcase
    end
  end

  assign req_o     = req_q;
  assign cause_o   = cause_q;
  assign pending_o = pend_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl; lines 2..5 edge-triggered, 0..1 level.
module tb_irq_pending_ctrl;

  localparam int         NUM_IRQ   = 8;
  localparam int         CAUSE_W   = 3;
  localparam logic [7:0] EDGE_MASK = 8'b0011_1100;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NUM_IRQ-1:0] irq_i;
  logic [NUM_IRQ-1:0] irq_en_i;
  logic               global_ie_i;
  logic               ack_i;
  logic               mret_i;
  logic               req_o;
  logic [CAUSE_W-1:0] cause_o;
  logic [NUM_IRQ-1:0] pending_o;

  int checks = 0;
  int errors = 0;

  irq_pending_ctrl #(
    .NUM_IRQ   (NUM_IRQ),
    .CAUSE_W   (CAUSE_W),
    .EDGE_MASK (EDGE_MASK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_i       (irq_i),
    .irq_en_i    (irq_en_i),
    .global_ie_i (global_ie_i),
    .ack_i       (ack_i),
    .mret_i      (mret_i),
    .req_o       (req_o),
    .cause_o     (cause_o),
    .pending_o   (pending_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; irq_i = '0; irq_en_i = 8'hFF; global_ie_i = 1'b1;
    ack_i = 1'b0; mret_i = 1'b0;
    repeat (2) tick();
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", req_o); end
    checks++; if (cause_o !== 3'd0) begin errors++; $display("FAIL reset_cause: got %0d want 0", cause_o); end
    checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL reset_pend: got %h want 00", pending_o); end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL reset_idle_req: got %0b want 0", req_o); end
  endtask

  task automatic test_edge_basic();
    irq_i[3] = 1'b1;
    tick();
    irq_i[3] = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      tick();
      checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL edge_early_req: got %0b want 0 at tick %0d", req_o, k); end
    end
    checks++; if (pending_o !== 8'h08) begin errors++; $display("FAIL edge_pend: got %h want 08", pending_o); end
    tick();
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL edge_req: got %0b want 1", req_o); end
    checks++; if (cause_o !== 3'd3) begin errors++; $display("FAIL edge_cause: got %0d want 3", cause_o); end
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL mret_in_req: got %0b want 1", req_o); end
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL ack_req: got %0b want 0", req_o); end
    checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL ack_pend: got %h want 00", pending_o); end
    irq_i[3] = 1'b1; tick(); irq_i[3] = 1'b0;
    repeat (LAT + 2) tick();
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    checks++; if (pending_o !== 8'h08) begin errors++; $display("FAIL trap_pend: got %h want 08", pending_o); end
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL trap_req: got %0b want 0", req_o); end
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL mret_edge_req: got %0b want 0", req_o); end
    tick();
    checks++; if (req_o !== 1'b1 || cause_o !== 3'd3) begin errors++; $display("FAIL post_mret_req: got req=%0b cause=%0d want req=1 cause=3", req_o, cause_o); end
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    mret_i = 1'b1; tick(); mret_i = 1'b0;
  endtask

  task automatic test_level_withdraw();
    irq_i[1] = 1'b1;
    repeat (LAT + 1) tick();
    checks++; if (req_o !== 1'b1 || cause_o !== 3'd1) begin errors++; $display("FAIL lvl_req: got req=%0b cause=%0d want req=1 cause=1", req_o, cause_o); end
    checks++; if (pending_o !== 8'h02) begin errors++; $display("FAIL lvl_pend: got %h want 02", pending_o); end
    irq_i[1] = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      checks++; if (req_o !== 1'b1) begin errors++; $display("FAIL lvl_hold: got %0b want 1 at tick %0d", req_o, k); end
    end
    tick();
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL lvl_withdraw: got %0b want 0", req_o); end
    checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL lvl_pend_drop: got %h want 00", pending_o); end
    irq_i[1] = 1'b1;
    repeat (LAT + 1) tick();
    checks++; if (req_o !== 1'b1 || cause_o !== 3'd1) begin errors++; $display("FAIL lvl_rereq: got req=%0b cause=%0d want req=1 cause=1", req_o, cause_o); end
    irq_i[1] = 1'b0;
    repeat (LAT + 1) tick();
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL lvl_rewithdraw: got %0b want 0", req_o); end
  endtask

  task automatic test_priority();
    irq_i[2] = 1'b1; irq_i[5] = 1'b1; tick(); irq_i[2] = 1'b0; irq_i[5] = 1'b0;
    repeat (LAT) tick();
    checks++; if (req_o !== 1'b1 || cause_o !== 3'd2) begin errors++; $display("FAIL prio_first: got req=%0b cause=%0d want req=1 cause=2", req_o, cause_o); end
    checks++; if (pending_o !== 8'h24) begin errors++; $display("FAIL prio_pend: got %h want 24", pending_o); end
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    checks++; if (pending_o !== 8'h20) begin errors++; $display("FAIL prio_ack_pend: got %h want 20", pending_o); end
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    tick();
    checks++; if (req_o !== 1'b1 || cause_o !== 3'd5) begin errors++; $display("FAIL prio_second: got req=%0b cause=%0d want req=1 cause=5", req_o, cause_o); end
    irq_i[2] = 1'b1; tick(); irq_i[2] = 1'b0;
    repeat (LAT) tick();
    checks++; if (req_o !== 1'b1 || cause_o !== 3'd5) begin errors++; $display("FAIL prio_no_preempt: got req=%0b cause=%0d want req=1 cause=5", req_o, cause_o); end
    checks++; if (pending_o !== 8'h24) begin errors++; $display("FAIL prio_pend2: got %h want 24", pending_o); end
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    tick();
    checks++; if (req_o !== 1'b1 || cause_o !== 3'd2) begin errors++; $display("FAIL prio_third: got req=%0b cause=%0d want req=1 cause=2", req_o, cause_o); end
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL prio_clear: got %h want 00", pending_o); end
    mret_i = 1'b1; tick(); mret_i = 1'b0;
  endtask

  task automatic test_global_ie();
    global_ie_i = 1'b0; irq_i[0] = 1'b1;
    repeat (LAT + 2) tick();
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL gie_masked_req: got %0b want 0", req_o); end
    checks++; if (pending_o !== 8'h01) begin errors++; $display("FAIL gie_pend: got %h want 01", pending_o); end
    global_ie_i = 1'b1; tick();
    checks++; if (req_o !== 1'b1 || cause_o !== 3'd0) begin errors++; $display("FAIL gie_req: got req=%0b cause=%0d want req=1 cause=0", req_o, cause_o); end
    global_ie_i = 1'b0; tick();
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL gie_withdraw: got %0b want 0", req_o); end
    irq_i[0] = 1'b0;
    repeat (LAT + 1) tick();
    checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL gie_pend_drop: got %h want 00", pending_o); end
    global_ie_i = 1'b1; tick();
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL gie_quiet: got %0b want 0", req_o); end
  endtask

  task automatic test_edge_ack_collision();
    irq_i[4] = 1'b1; tick(); irq_i[4] = 1'b0;
    repeat (LAT) tick();
    checks++; if (req_o !== 1'b1 || cause_o !== 3'd4) begin errors++; $display("FAIL coll_req: got req=%0b cause=%0d want req=1 cause=4", req_o, cause_o); end
    irq_i[4] = 1'b1;
    repeat (LAT - 1) tick();
    irq_i[4] = 1'b0; ack_i = 1'b1; tick(); ack_i = 1'b0;
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL coll_ack_req: got %0b want 0", req_o); end
    checks++; if (pending_o !== 8'h10) begin errors++; $display("FAIL coll_pend: got %h want 10", pending_o); end
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    tick();
    checks++; if (req_o !== 1'b1 || cause_o !== 3'd4) begin errors++; $display("FAIL coll_rereq: got req=%0b cause=%0d want req=1 cause=4", req_o, cause_o); end
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL coll_clear: got %h want 00", pending_o); end
    mret_i = 1'b1; tick(); mret_i = 1'b0;
  endtask

  task automatic test_reset_in_req();
    irq_i[3] = 1'b1; tick(); irq_i[3] = 1'b0;
    repeat (LAT) tick();
    checks++; if (req_o !== 1'b1 || cause_o !== 3'd3) begin errors++; $display("FAIL rst_pre_req: got req=%0b cause=%0d want req=1 cause=3", req_o, cause_o); end
    irq_i[5] = 1'b1; rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b want 0", req_o); end
    checks++; if (cause_o !== 3'd0) begin errors++; $display("FAIL rst_cause: got %0d want 0", cause_o); end
    checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL rst_pend: got %h want 00", pending_o); end
    repeat (LAT + 1) tick();
    checks++; if (req_o !== 1'b1 || cause_o !== 3'd5) begin errors++; $display("FAIL rst_high_edge: got req=%0b cause=%0d want req=1 cause=5", req_o, cause_o); end
    checks++; if (pending_o !== 8'h20) begin errors++; $display("FAIL rst_high_pend: got %h want 20", pending_o); end
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    repeat (3) tick();
    checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL rst_single_edge: got %h want 00", pending_o); end
    mret_i = 1'b1; tick(); mret_i = 1'b0;
    irq_i[5] = 1'b0; tick();
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL rst_final_req: got %0b want 0", req_o); end
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_level_withdraw();
    test_priority();
    test_global_ie();
    test_edge_ack_collision();
    test_reset_in_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
